// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES-128 key expansion. One round key is
// produced per cycle into an 11-entry store; the keys are then replayed in
// ascending (encrypt) or descending (decrypt) order under a next handshake.

// Forward AES S-box as a flat lookup table; entry 0 sits in the MSBs.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s_o = SBOX[a_i];
endmodule

module key_schedule_seq #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         encrypt,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  localparam logic [3:0] LAST = 4'(NROUNDS);

  state_t             state_q, state_d;
  logic [NROUNDS:0][127:0] ks_q;
  logic [3:0]         ptr_q, ptr_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  logic               ks_we;
  logic [3:0]         ks_widx;
  logic [127:0]       ks_wdata;

  // Expansion datapath: derive the key at ptr from the one stored at ptr-1.
  logic [3:0]   prev_idx;
  logic [127:0] prev_key, new_key;
  logic [31:0]  w3, rot, sub, t;
  logic [7:0]   rcon;
  logic [31:0]  nw0, nw1, nw2, nw3;

  assign prev_idx = ptr_q - 4'd1;
  assign prev_key = (prev_idx <= LAST) ? ks_q[prev_idx] : '0;
  assign w3       = prev_key[31:0];
  assign rot      = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*g +: 8]), .s_o(sub[8*g +: 8]));
  end

  // Round constant for the key currently being generated.
  always_comb begin
    rcon = 8'h00;
    case (ptr_q)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t       = sub ^ {rcon, 24'h0};
  assign nw0     = prev_key[127:96] ^ t;
  assign nw1     = prev_key[95:64]  ^ nw0;
  assign nw2     = prev_key[63:32]  ^ nw1;
  assign nw3     = prev_key[31:0]   ^ nw2;
  assign new_key = {nw0, nw1, nw2, nw3};

  // Next-state, pointer movement and key-store write control.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    ks_we    = 1'b0;
    ks_widx  = ptr_q;
    ks_wdata = new_key;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = EXPAND;
          ptr_d    = 4'd1;
          dir_d    = encrypt;
          ks_we    = 1'b1;
          ks_widx  = 4'd0;
          ks_wdata = key_in;
        end
      end
      EXPAND: begin
        ks_we = 1'b1;
        if (ptr_q == LAST) begin
          state_d = SERVE;
          ptr_d   = dir_q ? 4'd0 : LAST;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      SERVE: begin
        // start is deliberately not looked at here; next always wins.
        if (next) begin
          if (dir_q ? (ptr_q == LAST) : (ptr_q == 4'd0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d = dir_q ? ptr_q + 4'd1 : ptr_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Round-key store, cleared on reset so no stale key survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_q <= '0;
    end else if (ks_we && (ks_widx <= LAST)) begin
      ks_q[ks_widx] <= ks_wdata;
    end
  end

  assign key_valid = (state_q == SERVE);
  assign round_key = (key_valid && (ptr_q <= LAST)) ? ks_q[ptr_q] : '0;
  assign round_num = key_valid ? ptr_q : 4'd0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq using FIPS-197 key-expansion vectors.
module tb_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         encrypt;
  logic         next;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] K1 [0:10];
  logic [127:0] key2, key2_r10, key2_r9, other_key;

  key_schedule_seq #(.NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .encrypt(encrypt),
    .next(next), .round_key(round_key), .round_num(round_num),
    .key_valid(key_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k, input logic enc);
    start = 1'b1; key_in = k; encrypt = enc;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start edge until key_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!key_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 128'(key_valid), 128'd0);
    chk({tag, "_key"},   round_key,       128'd0);
    chk({tag, "_num"},   128'(round_num), 128'd0);
    chk({tag, "_busy"},  128'(busy),      128'd0);
    chk({tag, "_done"},  128'(done),      128'd0);
  endtask

  // Full run with next held high, checking every key and the done pulse.
  task automatic full_seq(input string tag, input logic enc);
    int cyc;
    int r;
    do_start(K1[0], enc);
    wait_valid(cyc);
    chk({tag, "_lat"}, 128'(cyc), 128'd10);
    next = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      r = enc ? i : 10 - i;
      chk($sformatf("%s_num%0d", tag, r), 128'(round_num), 128'(r));
      chk($sformatf("%s_key%0d", tag, r), round_key, K1[r]);
      tick();
    end
    next = 1'b0;
    chk({tag, "_end_valid"}, 128'(key_valid), 128'd0);
    chk({tag, "_end_busy"},  128'(busy),      128'd0);
    chk({tag, "_done"},      128'(done),      128'd1);
    tick();
    chk({tag, "_done_clr"},  128'(done),      128'd0);
  endtask

  initial begin
    int cyc;
    logic [127:0] hold_key;
    K1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    K1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    K1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    K1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    K1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    K1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    K1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    K1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    K1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    K1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    K1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    key2      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key2_r10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key2_r9   = 128'hac7766f319fadc2128d12941575c006e;
    other_key = 128'hffeeddccbbaa99887766554433221100;

    rst = 1'b1; start = 1'b0; key_in = '0; encrypt = 1'b0; next = 1'b0;
    #1;
    check_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Decrypt order with stalls and ignored start pulses.
    do_start(K1[0], 1'b0);
    chk("dec_busy_e0", 128'(busy), 128'd1);
    cyc = 0;
    while (!key_valid && cyc < 30) begin
      if (cyc == 3) begin start = 1'b1; key_in = other_key; encrypt = 1'b1; end
      else start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("dec_lat", 128'(cyc), 128'd10);
    chk("dec_num10", 128'(round_num), 128'd10);
    chk("dec_key10", round_key, K1[10]);
    hold_key = round_key;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); key_in = other_key;
      tick();
      chk($sformatf("stall_key%0d", i), round_key, K1[10]);
      chk($sformatf("stall_num%0d", i), 128'(round_num), 128'd10);
    end
    start = 1'b0;
    next = 1'b1; tick(); next = 1'b0;
    chk("dec_num9", 128'(round_num), 128'd9);
    chk("dec_key9", round_key, K1[9]);
    next = 1'b1;
    for (int r = 9; r >= 0; r--) begin
      chk($sformatf("dec_seq_key%0d", r), round_key, K1[r]);
      if (r == 5) start = 1'b1; else start = 1'b0;
      tick();
    end
    next = 1'b0; start = 1'b0;
    chk("dec_end_busy", 128'(busy), 128'd0);
    chk("dec_done", 128'(done), 128'd1);
    tick();
    chk("dec_done_clr", 128'(done), 128'd0);

    // Encrypt order, next held high, then back-to-back start in the done cycle.
    do_start(K1[0], 1'b1);
    wait_valid(cyc);
    chk("enc_lat", 128'(cyc), 128'd10);
    next = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("enc_num%0d", r), 128'(round_num), 128'(r));
      chk($sformatf("enc_key%0d", r), round_key, K1[r]);
      tick();
    end
    next = 1'b0;
    chk("enc_done", 128'(done), 128'd1);
    chk("enc_end_busy", 128'(busy), 128'd0);
    do_start(key2, 1'b0);
    chk("b2b_busy", 128'(busy), 128'd1);
    wait_valid(cyc);
    chk("b2b_lat", 128'(cyc), 128'd10);
    chk("b2b_num10", 128'(round_num), 128'd10);
    chk("b2b_key10", round_key, key2_r10);
    next = 1'b1; tick(); next = 1'b0;
    chk("b2b_key9", round_key, key2_r9);
    // Drain the remaining keys of this run.
    next = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin tick(); cyc++; end
    next = 1'b0;
    chk("b2b_drain", 128'(cyc), 128'd10);
    tick();

    // Reset mid-EXPAND.
    do_start(K1[0], 1'b0);
    repeat (4) tick();
    rst = 1'b1; #1;
    check_zero("rst_exp");
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-SERVE at round 6.
    do_start(K1[0], 1'b0);
    wait_valid(cyc);
    next = 1'b1;
    repeat (4) tick();
    next = 1'b0;
    chk("rst_srv_num6", 128'(round_num), 128'd6);
    #2;
    rst = 1'b1; #1;
    check_zero("rst_srv");
    tick();
    rst = 1'b0;
    tick();

    full_seq("post_rst_dec", 1'b0);
    full_seq("post_rst_enc", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
